hilo_unit: RTL
==============

Name: hilo_unit

Overview:
- Architectural HI/LO register stage directly downstream of the combinational multiply/divide unit.
- Captures its HI/LO results after a configurable multi-cycle latency and stalls the issuing pipeline stage meanwhile.
- Services MTHI/MTLO writes and MFHI/MFLO reads; honours pipeline flush (exception/eret).

Parameters:
- MUL_LAT, 4, stall cycles for MULT/MULTU (>=2)
- DIV_LAT, 33, stall cycles for DIV/DIVU (>=2)

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- op_valid  in  1  EX-stage instruction valid (held high while stall=1)
- op_code  in  5  ALUctr encoding: MULTU=01000, MULT=01001, DIVU=01010, DIV=01011, MTHI=10100, MTLO=10101
- md_hi  in  32  HI result from mult/div unit (stable while stall=1)
- md_lo  in  32  LO result from mult/div unit
- mt_data  in  32  rs value for MTHI/MTLO
- flush  in  1  synchronous pipeline flush
- mf_sel  in  1  1=read HI, 0=read LO
- rd_data  out  32  combinational mf_sel ? hi : lo
- hi  out  32  HI register
- lo  out  32  LO register
- stall  out  1  hold EX and earlier stages
- busy  out  1  state==BUSY

Behaviour:
- Reset: hi=0, lo=0, state=IDLE, cnt=0, stall=0, busy=0.
- is_md = op_code in {MULTU,MULT,DIVU,DIV}. lat = DIV_LAT for DIV/DIVU, else MUL_LAT.
- stall = (IDLE & op_valid & is_md & ~flush) | BUSY. Combinational.
- IDLE:
  - op_valid & is_md & ~flush: cnt<=lat-2, go BUSY.
  - op_valid & MTHI & ~flush: hi<=mt_data; lo unchanged; stay IDLE; no stall.
  - op_valid & MTLO & ~flush: lo<=mt_data; hi unchanged; stay IDLE; no stall.
  - Other op_code: no action.
- BUSY:
  - cnt!=0: cnt<=cnt-1.
  - cnt==0: hi<=md_hi, lo<=md_lo, go DONE.
  - Total stall = lat cycles: acceptance cycle plus lat-1 BUSY cycles.
- DONE:
  - stall=0; pipeline advances the completed instruction at this edge.
  - op_valid ignored (same instruction still presented); unconditionally go IDLE.
  - Back-to-back mult/div therefore accepted in the following IDLE cycle.
- flush (any state): next state IDLE, cnt=0, no hi/lo write. Flush beats capture on the same edge. stall=0 in any cycle where flush=1 and state is IDLE.
- Reads: rd_data reflects registered hi/lo. MT written at edge E becomes visible the cycle after E; pipeline handles same-cycle hazards.
- Divide by zero: md_hi/md_lo captured as presented (architecturally UNPREDICTABLE); no trap.
- resetn low mid-operation: immediate return to reset values; pending result discarded.

Optional Feature:
- Macro HILO_PERF_EN.
- Defined: adds output stall_cycles [31:0]. Increments each cycle stall=1, wraps at 2^32, reset to 0 by resetn only (not by flush).
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package: op_code constants (MULTU..MTLO), FSM state encoding IDLE/BUSY/DONE (2 bits), counter width = $clog2(DIV_LAT).
- One natural sub-module, hilo_lat_fsm: state, cnt, stall/busy/capture strobe. Parent holds hi/lo registers and the read mux.

Test Plan:
- Reset then release -> hi=lo=0, stall=0; mf_sel=1 gives rd_data=0.
- MULT held valid, md_hi=FFFFFFFF, md_lo=FFFFFFFA (-3*2), MUL_LAT=4 -> stall high exactly 4 cycles, hi/lo updated at the 4th edge, DONE cycle stall=0.
- DIVU 7/2, md_hi=1, md_lo=3, DIV_LAT=33 -> 33 stall cycles, then hi=1, lo=3; MFLO next cycle reads 3.
- MTHI mt_data=12345678 with lo=AAAAAAAA -> hi=12345678, lo still AAAAAAAA, stall never asserted.
- DIV accepted, flush at BUSY cycle 10 -> IDLE next cycle, stall=0, hi/lo unchanged; flush on the capture edge also leaves hi/lo unchanged.
- resetn pulsed low mid-BUSY -> outputs immediately 0/IDLE. With HILO_PERF_EN, MULT then DIV (defaults) gives stall_cycles=37.

Source files
------------

// File: rtl/hilo_pkg.sv
// hilo_pkg: shared definitions for the HI/LO register stage.
//   - op_code constants for the mult/div and move-to instructions
//   - FSM state encoding (IDLE/BUSY/DONE, 2 bits)
//   - op request struct and small decode helpers
//   - latency-counter width helper
package hilo_pkg;

  localparam logic [4:0] OP_MULTU = 5'b01000;
  localparam logic [4:0] OP_MULT  = 5'b01001;
  localparam logic [4:0] OP_DIVU  = 5'b01010;
  localparam logic [4:0] OP_DIV   = 5'b01011;
  localparam logic [4:0] OP_MTHI  = 5'b10100;
  localparam logic [4:0] OP_MTLO  = 5'b10101;

  // Counter width for the default DIV_LAT of 33.
  localparam int CNT_W_DEF = $clog2(33);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } st_e;

  typedef struct packed {
    logic       vld;
    logic [4:0] op;
  } op_req_t;

  function automatic logic is_md(input logic [4:0] op);
    return (op == OP_MULTU) || (op == OP_MULT) || (op == OP_DIVU) || (op == OP_DIV);
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

  // Wide enough to hold lat-2 for the larger of the two latencies.
  function automatic int cnt_w(input int mul_lat, input int div_lat);
    int m;
    m = (mul_lat > div_lat) ? mul_lat : div_lat;
    return (m < 3) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/hilo_lat_fsm.sv
// hilo_lat_fsm: latency sequencer for the HI/LO stage.
// Ports:
//   clk, resetn   clock / async active-low reset
//   req           EX-stage op request (valid + op_code)
//   flush         synchronous pipeline flush
//   stall         hold EX and earlier stages (combinational)
//   busy          state == BUSY
//   idle          state == IDLE (qualifies MTHI/MTLO writes)
//   cap           strobe: capture md_hi/md_lo at this edge
module hilo_lat_fsm
  import hilo_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 33
) (
  input  logic    clk,
  input  logic    resetn,
  input  op_req_t req,
  input  logic    flush,
  output logic    stall,
  output logic    busy,
  output logic    idle,
  output logic    cap
);

  localparam int CNT_W = cnt_w(MUL_LAT, DIV_LAT);
  localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_LAT - 2);

  st_e              state, nstate;
  logic [CNT_W-1:0] cnt, ncnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= nstate;
      cnt   <= ncnt;
    end
  end

  always_comb begin
    nstate = state;
    ncnt   = cnt;
    stall  = 1'b0;
    cap    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (req.vld && is_md(req.op) && !flush) begin
          stall  = 1'b1;
          nstate = ST_BUSY;
          ncnt   = is_div(req.op) ? DIV_INIT : MUL_INIT;
        end
      end
      ST_BUSY: begin
        stall = 1'b1;
        if (cnt != '0) begin
          ncnt = cnt - 1'b1;
        end else begin
          cap    = 1'b1;
          nstate = ST_DONE;
        end
      end
      // Completed instruction leaves EX this edge; its op_valid is stale.
      ST_DONE: nstate = ST_IDLE;
      default: nstate = ST_IDLE;
    endcase
    // Flush wins over capture and over acceptance.
    if (flush) begin
      nstate = ST_IDLE;
      ncnt   = '0;
      cap    = 1'b0;
    end
  end

  assign busy = (state == ST_BUSY);
  assign idle = (state == ST_IDLE);

endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: architectural HI/LO registers behind the mult/div unit.
// Optional feature: define HILO_PERF_EN to add the stall_cycles counter.
// Ports:
//   clk, resetn        clock / async active-low reset
//   op_valid, op_code  EX-stage instruction (held while stall=1)
//   md_hi, md_lo       mult/div results (stable while stall=1)
//   mt_data            rs value for MTHI/MTLO
//   flush              synchronous pipeline flush
//   mf_sel             1: rd_data=hi, 0: rd_data=lo
//   rd_data            combinational read of the registered HI/LO
//   hi, lo             HI/LO registers
//   stall, busy        pipeline hold / FSM in BUSY
//   stall_cycles       (HILO_PERF_EN) count of stalled cycles, wraps
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 33
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [4:0]  op_code,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  input  logic [31:0] mt_data,
  input  logic        flush,
  input  logic        mf_sel,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        stall,
  output logic        busy
`ifdef HILO_PERF_EN
  ,output logic [31:0] stall_cycles
`endif
);

  op_req_t req;
  logic    idle, cap, mt_ok;

  assign req = '{vld: op_valid, op: op_code};

  hilo_lat_fsm #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_fsm (
    .clk    (clk),
    .resetn (resetn),
    .req    (req),
    .flush  (flush),
    .stall  (stall),
    .busy   (busy),
    .idle   (idle),
    .cap    (cap)
  );

  // Move-to writes only in IDLE; DONE still presents the finished mult/div.
  assign mt_ok = idle && op_valid && !flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi <= '0;
      lo <= '0;
    end else if (cap) begin
      hi <= md_hi;
      lo <= md_lo;
    end else if (mt_ok) begin
      if (op_code == OP_MTHI) hi <= mt_data;
      if (op_code == OP_MTLO) lo <= mt_data;
    end
  end

  assign rd_data = mf_sel ? hi : lo;

`ifdef HILO_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)    stall_cycles <= '0;
    else if (stall) stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule
